// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay arbiter: FSM state encoding,
// a constant-safe clog2 and the settle-phase length.
package delay_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_t;

    // Settle counter width; supports LATENCY up to 256.
    localparam int SETTLE_CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int settle_cycles(input int latency);
        return (latency < 1) ? 1 : latency;
    endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// Requester-side bundle of the delay arbiter: request levels, packed delays,
// abort, and the per-channel grant/done/error handshake.
interface delay_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] delay;
    logic               abort;
    logic [N-1:0]       grant;
    logic [N-1:0]       done;
    logic [N-1:0]       error;
    logic               busy;

    modport master (output req, delay, abort, input grant, done, error, busy);
    modport slave  (input req, delay, abort, output grant, done, error, busy);
endinterface

// File: rtl/delay_arbiter_counter.sv
// Down-counting timer with terminal-count strobe. Enable is ignored for
// LATENCY cycles after rst falls; strobe fires on the enabled cycle at zero.
module counter_with_strobe
    import delay_arb_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] reset_value,
    output logic             strobe
);

    localparam int WW = clog2(LATENCY + 2);

    logic [WIDTH-1:0] count;
    logic [WW-1:0]    warm;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= reset_value;
            warm  <= WW'(LATENCY);
        end else if (warm != '0) begin
            warm <= warm - 1'b1;
        end else if (enable) begin
            count <= (count == '0) ? reset_value : count - 1'b1;
        end
    end

    assign strobe = enable && (warm == '0) && (count == '0);

endmodule

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N (N need not be a power of two).
module rr_pick
    import delay_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                idx          = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Shares one counter_with_strobe between N one-shot delay requesters using
// round-robin arbitration; pulses done/error on the granted channel.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | no owner; timer held in reset; arbitrate on |req
//  ST_SETTLE | owner latched; timer reset first cycle, enable held low
//  ST_RUN    | timer enabled; wait for strobe or abort
//  ST_FINISH | one cycle: done or error pulse, advance rr pointer
module delay_arbiter
    import delay_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 0
) (
    input  logic           clk,
    input  logic           rst,
    delay_arbiter_if.slave bus
);

    localparam int PW         = clog2(N);
    localparam int SETTLE_CYC = settle_cycles(LATENCY);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

    arb_state_t              state;
    arb_state_t              state_nx;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           job_ch;
    logic [WIDTH-1:0]        job_delay;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [N-1:0]            grant_q;
    logic [N-1:0]            done_q;
    logic [N-1:0]            error_q;

    logic [N-1:0]            pick_onehot;
    logic [PW-1:0]           pick_idx;
    logic [WIDTH-1:0]        pick_delay;
    logic                    timer_rst;
    logic                    timer_en;
    logic                    timer_strobe;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    assign pick_delay = bus.delay[int'(pick_idx)*WIDTH +: WIDTH];

    // Timer reset everywhere except RUN and the later SETTLE cycles, so
    // enable can never overlap it.
    assign timer_rst = rst || !((state == ST_RUN) ||
                                ((state == ST_SETTLE) && (settle_cnt != SETTLE_LAST)));
    assign timer_en  = (state == ST_RUN) && !rst;

    counter_with_strobe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_timer (
        .clk         (clk),
        .rst         (timer_rst),
        .enable      (timer_en),
        .reset_value (job_delay),
        .strobe      (timer_strobe)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (|bus.req) state_nx = (pick_delay < WIDTH'(2)) ? ST_FINISH : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.abort)              state_nx = ST_FINISH;
                else if (settle_cnt == '0)  state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort || timer_strobe) state_nx = ST_FINISH;
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            job_ch     <= '0;
            job_delay  <= WIDTH'(2);
            settle_cnt <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            error_q    <= '0;
        end else begin
            state   <= state_nx;
            done_q  <= '0;
            error_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        job_ch     <= pick_idx;
                        job_delay  <= pick_delay;
                        grant_q    <= pick_onehot;
                        settle_cnt <= SETTLE_LAST;
                        if (state_nx == ST_FINISH) error_q <= pick_onehot;
                    end
                end
                ST_SETTLE, ST_RUN: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                    // Abort takes priority over a coincident strobe.
                    if (state_nx == ST_FINISH) begin
                        if (bus.abort) error_q <= grant_q;
                        else           done_q  <= grant_q;
                    end
                end
                ST_FINISH: begin
                    grant_q <= '0;
                    ptr     <= (job_ch == PW'(N - 1)) ? '0 : job_ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;
    assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter: single job, fairness, reject, abort,
// reset mid-job and LATENCY=2 timing, with hand-computed expectations.
module tb_delay_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    logic rule_viol    = 1'b0;
    logic unstable     = 1'b0;
    logic en_in_reject = 1'b0;
    logic in_reject    = 1'b0;
    logic in_t6        = 1'b0;

    delay_arbiter_if #(.N(4), .WIDTH(8)) ifc0 ();
    delay_arbiter_if #(.N(4), .WIDTH(8)) ifc2 ();

    delay_arbiter #(.N(4), .WIDTH(8), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    delay_arbiter #(.N(4), .WIDTH(8), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut0.timer_en && dut0.timer_rst) rule_viol <= 1'b1;
        if (dut2.timer_en && dut2.timer_rst) rule_viol <= 1'b1;
        if (in_reject && dut0.timer_en)      en_in_reject <= 1'b1;
        if (in_t6 && ifc2.busy && dut2.job_delay != 8'd255) unstable <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc0.req = '0; ifc0.abort = 1'b0;
        ifc2.req = '0; ifc2.abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Request ch with delay d in the current cycle; wait for done/error.
    task automatic run_job(input int ch, input int d, input int exp_lat,
                           input logic exp_err, input string tag);
        int lat;
        logic [3:0] oh;
        logic [7:0] dv;
        oh = 4'(1 << ch);
        dv = d[7:0];
        ifc0.delay[ch*8 +: 8] = dv;
        ifc0.req[ch] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) chk({tag, "_grant_first"}, 32'(ifc0.grant), 32'(oh));
        end while ((ifc0.done | ifc0.error) == '0 && lat < 400);
        chk({tag, "_lat"},   lat, exp_lat);
        chk({tag, "_grant"}, 32'(ifc0.grant), 32'(oh));
        chk({tag, "_done"},  32'(ifc0.done),  exp_err ? 32'd0 : 32'(oh));
        chk({tag, "_error"}, 32'(ifc0.error), exp_err ? 32'(oh) : 32'd0);
        ifc0.req[ch] = 1'b0;
        tick();
        chk({tag, "_busy_after"},  32'(ifc0.busy),  32'd0);
        chk({tag, "_grant_after"}, 32'(ifc0.grant), 32'd0);
        chk({tag, "_done_after"},  32'(ifc0.done),  32'd0);
    endtask

    initial begin
        int cyc;
        int nstart;
        int lat;
        logic [3:0] prev_g;
        logic [3:0] g_seq [5];
        int         g_cyc [5];
        logic [3:0] exp_g [5];
        logic       seen_done;

        ifc0.req = '0; ifc0.delay = '0; ifc0.abort = 1'b0;
        ifc2.req = '0; ifc2.delay = '0; ifc2.abort = 1'b0;
        do_reset();

        chk("rst_grant", 32'(ifc0.grant), 32'd0);
        chk("rst_done",  32'(ifc0.done),  32'd0);
        chk("rst_error", 32'(ifc0.error), 32'd0);
        chk("rst_busy",  32'(ifc0.busy),  32'd0);
        chk("rst_busy2", 32'(ifc2.busy),  32'd0);

        // 1. single job: done D+3 = 8 cycles after accept
        run_job(2, 5, 8, 1'b0, "single");

        // 2. fairness with all four requesting
        do_reset();
        ifc0.delay = {8'd3, 8'd3, 8'd3, 8'd3};
        ifc0.req = 4'b1111;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        prev_g = '0; nstart = 0; cyc = 0;
        while (nstart < 5 && cyc < 100) begin
            tick();
            cyc++;
            if (ifc0.grant != '0 && prev_g == '0) begin
                g_seq[nstart] = ifc0.grant;
                g_cyc[nstart] = cyc;
                nstart++;
            end
            prev_g = ifc0.grant;
        end
        ifc0.req = '0;
        chk("fair_count", nstart, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < nstart) chk($sformatf("fair_order%0d", i), 32'(g_seq[i]), 32'(exp_g[i]));
            if (i > 0 && i < nstart) chk($sformatf("fair_gap%0d", i), g_cyc[i] - g_cyc[i-1], 7);
        end
        cyc = 0;
        while (ifc0.busy && cyc < 50) begin tick(); cyc++; end
        chk("fair_drain", 32'(ifc0.busy), 32'd0);

        // 3. reject delays 1 and 0
        in_reject = 1'b1;
        run_job(1, 1, 1, 1'b1, "rej1");
        run_job(1, 0, 1, 1'b1, "rej0");
        tick();
        in_reject = 1'b0;
        chk("rej_no_enable", 32'(en_in_reject), 32'd0);

        // 4a. abort in third RUN cycle of delay 10
        ifc0.delay[7:0] = 8'd10;
        ifc0.req[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ifc0.abort = 1'b1;
        tick();
        ifc0.abort = 1'b0;
        ifc0.req[0] = 1'b0;
        chk("abort_error", 32'(ifc0.error), 32'h1);
        chk("abort_done",  32'(ifc0.done),  32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ifc0.done != '0 || ifc0.error != '0) seen_done = 1'b1;
        end
        chk("abort_quiet", 32'(seen_done), 32'd0);
        chk("abort_idle",  32'(ifc0.busy),  32'd0);

        // 4b. abort coincident with strobe (delay 3 strobes 5 cycles after accept)
        ifc0.delay[31:24] = 8'd3;
        ifc0.req[3] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("coll_strobe", 32'(dut0.timer_strobe), 32'd1);
        ifc0.abort = 1'b1;
        tick();
        ifc0.abort = 1'b0;
        ifc0.req[3] = 1'b0;
        chk("coll_error", 32'(ifc0.error), 32'h8);
        chk("coll_done",  32'(ifc0.done),  32'h0);
        tick();
        chk("coll_after", 32'(ifc0.done | ifc0.error), 32'h0);

        // 5. reset mid-RUN, then clean job
        ifc0.delay[15:8] = 8'd200;
        ifc0.req[1] = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        ifc0.req = '0;
        tick();
        rst = 1'b0;
        chk("mid_rst_grant", 32'(ifc0.grant), 32'd0);
        chk("mid_rst_done",  32'(ifc0.done),  32'd0);
        chk("mid_rst_error", 32'(ifc0.error), 32'd0);
        chk("mid_rst_busy",  32'(ifc0.busy),  32'd0);
        run_job(2, 4, 7, 1'b0, "post_rst");

        // 6. LATENCY=2, delay 255: done 260 cycles after accept
        in_t6 = 1'b1;
        ifc2.delay[7:0] = 8'd255;
        ifc2.req[0] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ifc2.done == '0 && ifc2.error == '0 && lat < 400);
        chk("lat2_cycles", lat, 260);
        chk("lat2_done",   32'(ifc2.done), 32'h1);
        ifc2.req[0] = 1'b0;
        tick();
        in_t6 = 1'b0;
        chk("lat2_idle",   32'(ifc2.busy), 32'd0);
        tick();
        chk("reset_value_stable", 32'(unstable),  32'd0);
        chk("en_vs_timer_rst",    32'(rule_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
